pll_lock_mgr: RTL and testbench

Lock supervisor for the ADDA PLL, on the consuming side of the PLL's reset/lock interface.
- Drives the PLL reset input and watches the PLL lock output.
- Releases the ADDA-domain reset only after lock has been stable for a programmed time.
- Re-initialises the PLL on lock loss or lock timeout, with bounded retries, and reports failure.
- Runs on the free-running 50 MHz board clock that also feeds the PLL input, so it works before any PLL output is valid.

---
 rtl/pll_lock_mgr.sv | 186 ++++++++++++++++++
 tb/tb_pll_lock_mgr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr
//
// Lock supervisor for the ADDA PLL. Pulses the PLL reset, waits for the
// (asynchronous) PLL lock to be stable for a programmed time, then releases
// the ADDA-domain reset. Lock loss or lock timeout re-initialises the PLL,
// with a bounded number of retries before a sticky failure is reported.
// Runs on the free-running board clock so it works before the PLL is up.
//
// Build option:
//   PLL_LOCK_MGR_AUTO_RELOCK_EN defined   - timeouts retry with a fresh PLL
//                                            reset pulse (up to MAX_RETRY), and
//                                            lock loss in RUN re-pulses the PLL.
//   PLL_LOCK_MGR_AUTO_RELOCK_EN undefined - no retries: timeout goes straight
//                                            to FAIL, lock loss in RUN returns
//                                            to WAIT_LOCK without a PLL pulse.
//
// Ports:
//   sys_clk       in   50 MHz free-running clock
//   sys_rst_n     in   synchronous active-low reset
//   pll_lock      in   PLL lock, asynchronous to sys_clk
//   pll_rst       out  PLL reset, active-high
//   adda_rst_n    out  active-low reset for the ADDA logic
//   lock_ok       out  high only in RUN
//   lock_fail     out  sticky failure flag (cleared only by sys_rst_n)
//   retry_cnt     out  [1:0] retries used in the current acquisition
//   lock_loss_cnt out  [7:0] lock losses seen in RUN, saturating at 255
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESET_PLL | pll_rst high for PLL_RST_CYC cycles
// WAIT_LOCK | PLL released, waiting up to RELOCK_TIMEOUT_CYC for lock
// STABLE    | lock seen, must hold for LOCK_STABLE_CYC consecutive cycles
// RUN       | ADDA reset released, watching for lock loss
// FAIL      | retries exhausted, everything held off until sys_rst_n

module pll_lock_mgr #(
    parameter int PLL_RST_CYC        = 16,
    parameter int LOCK_STABLE_CYC    = 1024,
    parameter int RELOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRY          = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       adda_rst_n,
    output logic       lock_ok,
    output logic       lock_fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

`ifdef PLL_LOCK_MGR_AUTO_RELOCK_EN
    localparam bit AUTO_RELOCK = 1'b1;
`else
    localparam bit AUTO_RELOCK = 1'b0;
`endif

    localparam int CNT_MAX =
        (PLL_RST_CYC > LOCK_STABLE_CYC)
            ? ((PLL_RST_CYC > RELOCK_TIMEOUT_CYC) ? PLL_RST_CYC : RELOCK_TIMEOUT_CYC)
            : ((LOCK_STABLE_CYC > RELOCK_TIMEOUT_CYC) ? LOCK_STABLE_CYC : RELOCK_TIMEOUT_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);

    // Terminal counts: a state entered on edge X is left on edge X+N.
    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_meta;
    logic          lock_s;
    // Low on the first edge after reset release so that edge counts as the
    // entry into RESET_PLL: the first PLL pulse then lasts a full
    // PLL_RST_CYC cycles measured from release.
    logic          armed;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            armed         <= 1'b0;
            pll_rst       <= 1'b1;
            adda_rst_n    <= 1'b0;
            lock_ok       <= 1'b0;
            lock_fail     <= 1'b0;
            retry_cnt     <= 2'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            armed     <= 1'b1;

            if (armed) begin
                case (state)
                    RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    WAIT_LOCK: begin
                        // Lock is checked first so it wins over a coincident timeout.
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt <= '0;
                            if (AUTO_RELOCK && ({30'd0, retry_cnt} < 32'(MAX_RETRY))) begin
                                state     <= RESET_PLL;
                                pll_rst   <= 1'b1;
                                retry_cnt <= retry_cnt + 2'd1;
                            end else begin
                                state     <= FAIL;
                                lock_fail <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state      <= RUN;
                            cnt        <= '0;
                            retry_cnt  <= 2'd0;
                            adda_rst_n <= 1'b1;
                            lock_ok    <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    RUN: begin
                        if (!lock_s) begin
                            cnt        <= '0;
                            adda_rst_n <= 1'b0;
                            lock_ok    <= 1'b0;
                            if (lock_loss_cnt != 8'hFF) begin
                                lock_loss_cnt <= lock_loss_cnt + 8'd1;
                            end
                            if (AUTO_RELOCK) begin
                                state   <= RESET_PLL;
                                pll_rst <= 1'b1;
                            end else begin
                                state <= WAIT_LOCK;
                            end
                        end
                    end

                    FAIL: begin
                        cnt <= '0;
                    end

                    default: begin
                        state      <= RESET_PLL;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        adda_rst_n <= 1'b0;
                        lock_ok    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_mgr.sv
module tb_pll_lock_mgr;

    localparam int N_RST   = 4;
    localparam int N_STB   = 16;
    localparam int N_TO    = 100;
    localparam int N_RETRY = 2;

`ifdef PLL_LOCK_MGR_AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pll_lock;
    logic       pll_rst;
    logic       adda_rst_n;
    logic       lock_ok;
    logic       lock_fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pll_lock_mgr #(
        .PLL_RST_CYC       (N_RST),
        .LOCK_STABLE_CYC   (N_STB),
        .RELOCK_TIMEOUT_CYC(N_TO),
        .MAX_RETRY         (N_RETRY)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pll_lock     (pll_lock),
        .pll_rst      (pll_rst),
        .adda_rst_n   (adda_rst_n),
        .lock_ok      (lock_ok),
        .lock_fail    (lock_fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: phase plus the edge number at which it was entered.
    // Durations are checked as edge-number differences.
    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    int m_phase;
    int m_start;
    int m_retry;
    int m_loss;
    bit m_valid = 1'b0;
    bit m_fresh = 1'b0;
    bit m_hist[$];

    always @(posedge sys_clk) begin
        logic r, l, ls;
        r = sys_rst_n;
        l = pll_lock;
        cyc++;
        #1;
        if (!r) begin
            m_valid = 1'b1;
            m_fresh = 1'b1;
            m_phase = PH_PULSE;
            m_retry = 0;
            m_loss  = 0;
            m_hist  = '{1'b0, 1'b0};
        end else if (m_valid) begin
            // lock as seen by the FSM: pll_lock sampled two edges earlier
            ls = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(l);
            if (m_fresh) begin
                m_fresh = 1'b0;
                m_start = cyc;
            end else begin
                case (m_phase)
                    PH_PULSE: if (cyc - m_start == N_RST) begin
                        m_phase = PH_WAIT;
                        m_start = cyc;
                    end
                    PH_WAIT: if (ls) begin
                        m_phase = PH_STABLE;
                        m_start = cyc;
                    end else if (cyc - m_start == N_TO) begin
                        m_start = cyc;
                        if (AUTO && m_retry < N_RETRY) begin
                            m_retry++;
                            m_phase = PH_PULSE;
                        end else begin
                            m_phase = PH_FAIL;
                        end
                    end
                    PH_STABLE: if (!ls) begin
                        m_phase = PH_WAIT;
                        m_start = cyc;
                    end else if (cyc - m_start == N_STB) begin
                        m_phase = PH_RUN;
                        m_retry = 0;
                    end
                    PH_RUN: if (!ls) begin
                        m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                        m_phase = AUTO ? PH_PULSE : PH_WAIT;
                        m_start = cyc;
                    end
                    default: ;
                endcase
            end
        end
        if (m_valid) begin
            check("pll_rst",       pll_rst,       32'(m_phase == PH_PULSE));
            check("adda_rst_n",    adda_rst_n,    32'(m_phase == PH_RUN));
            check("lock_ok",       lock_ok,       32'(m_phase == PH_RUN));
            check("lock_fail",     lock_fail,     32'(m_phase == PH_FAIL));
            check("retry_cnt",     retry_cnt,     32'(m_retry));
            check("lock_loss_cnt", lock_loss_cnt, 32'(m_loss));
        end
    end

    task automatic do_reset(input int n);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        pll_lock  = 1'b0;
        repeat (n) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    int  a_edge, r_edge, d_edge, f_edge, rel_edge;
    int  cnt_hi, falls, drop;
    bit  prev, fell, done, early;

    initial begin
        sys_rst_n = 1'b0;
        pll_lock  = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("reset_pll_rst",    pll_rst,       1);
        check("reset_adda_rst_n", adda_rst_n,    0);
        check("reset_lock_ok",    lock_ok,       0);
        check("reset_lock_fail",  lock_fail,     0);
        check("reset_retry_cnt",  retry_cnt,     0);
        check("reset_loss_cnt",   lock_loss_cnt, 0);
        sys_rst_n = 1'b1;

        // Release, lock rises 10 cycles later and holds.
        cnt_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (pll_rst) cnt_hi++;
        end
        check("release_pulse_width", cnt_hi, 4);
        pll_lock = 1'b1;
        a_edge = cyc + 1;
        r_edge = -1;
        for (int i = 0; i < 60 && r_edge < 0; i++) begin
            @(negedge sys_clk);
            if (adda_rst_n) r_edge = cyc;
        end
        // sampling edge counted as the 1st: rise on the 19th edge
        check("lock_to_release_edges", r_edge - a_edge, 18);
        check("release_lock_ok", lock_ok, 1);
        check("release_retry_cnt", retry_cnt, 0);

        // Lock never arrives: retries, then sticky failure.
        do_reset(3);
        rel_edge = cyc + 1;
        falls = 0;
        prev = 1'b1;
        f_edge = -1;
        for (int i = 0; i < 500 && f_edge < 0; i++) begin
            @(negedge sys_clk);
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (lock_fail) f_edge = cyc;
        end
        check("timeout_fail_seen", lock_fail, 1);
        check("timeout_fail_edge", f_edge - rel_edge, AUTO ? 312 : 104);
        check("timeout_pulses", falls, AUTO ? 3 : 1);
        check("timeout_retry_cnt", retry_cnt, AUTO ? 2 : 0);
        repeat (30) @(negedge sys_clk);
        check("fail_sticky", lock_fail, 1);
        check("fail_adda_held", adda_rst_n, 0);
        check("fail_pll_rst_low", pll_rst, 0);

        // Lock drop while in STABLE restarts the stability window.
        do_reset(3);
        repeat (8) @(negedge sys_clk);
        pll_lock = 1'b1;
        a_edge = cyc + 1;
        repeat (12) @(negedge sys_clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge sys_clk);
        pll_lock = 1'b1;
        a_edge = cyc + 1;
        r_edge = -1;
        early = 1'b0;
        for (int i = 0; i < 80 && r_edge < 0; i++) begin
            @(negedge sys_clk);
            if (adda_rst_n) r_edge = cyc;
        end
        check("stable_restart_edges", r_edge - a_edge, 18);

        // Lock losses in RUN, ending with the counter saturated.
        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(0, 4)) @(negedge sys_clk);
            pll_lock = 1'b0;
            d_edge = cyc + 1;
            drop = $urandom_range(1, 6);
            cnt_hi = 0;
            fell = 1'b0;
            done = 1'b0;
            for (int k = 1; k <= 200 && !done; k++) begin
                @(negedge sys_clk);
                if (k == drop) pll_lock = 1'b1;
                if (pll_rst) cnt_hi++;
                if (!fell && !adda_rst_n) begin
                    fell = 1'b1;
                    f_edge = cyc;
                end else if (fell && adda_rst_n) begin
                    done = 1'b1;
                end
            end
            check("loss_relocked", done, 1);
            check("loss_pll_pulse", cnt_hi, AUTO ? 4 : 0);
            if (it == 0) begin
                // sampling edge counted as the 1st: fall on the 3rd edge
                check("loss_fall_edges", f_edge - d_edge, 2);
                check("loss_cnt_first", lock_loss_cnt, 1);
            end
        end
        check("loss_cnt_saturated", lock_loss_cnt, 255);

        // Reset in RUN takes effect on the next edge.
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check("midrun_pll_rst", pll_rst, 1);
        check("midrun_adda_rst_n", adda_rst_n, 0);
        check("midrun_lock_ok", lock_ok, 0);
        check("midrun_loss_cnt", lock_loss_cnt, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Random lock activity with occasional resets; the model checks every cycle.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                sys_rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge sys_clk);
                sys_rst_n = 1'b1;
            end
            pll_lock = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) @(negedge sys_clk);
        end

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: run did not reach its end, edge %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
